// File: rtl/bus_breakin.sv
// bus_breakin: assembles FRAME_WORDS 6-bit breakout words into one frame behind a registered valid/ready stage.
// Optional BUS_BREAKIN_PARITY_EN adds per-word even parity checking (in_par, par_err, frame_bad).
module bus_breakin #(
  parameter int FRAME_WORDS = 2,
  localparam int FRAME_W = 6 * FRAME_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         in_word,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] out_frame,
  output logic [1:0]         fld_hi,
  output logic [1:0]         fld_gated,
  output logic [1:0]         fld_lo,
  output logic [7:0]         frame_cnt
`ifdef BUS_BREAKIN_PARITY_EN
  ,
  input  logic               in_par,
  output logic               par_err,
  output logic               frame_bad
`endif
);
  localparam int CW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_WORDS - 1);
  logic [CW-1:0] cnt;
  logic [FRAME_W-1:0] asm_q, asm_d;
  logic last, acc, done;
  assign last = cnt == LAST;
  assign in_ready = !(last && out_valid && !out_ready);
  assign acc = in_valid && in_ready;
  assign done = acc && last && !flush;
  always_comb begin
    asm_d = asm_q;
    asm_d[6*cnt +: 6] = in_word;
  end
  // A completing word and a handshake in the same cycle keep out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      asm_q <= '0;
      out_valid <= 1'b0;
      out_frame <= '0;
      {fld_hi, fld_gated, fld_lo} <= 6'd0;
      frame_cnt <= 8'd0;
    end else begin
      if (flush) begin
        cnt <= '0;
        asm_q <= '0;
      end else if (acc) begin
        cnt <= last ? '0 : cnt + 1'b1;
        asm_q <= asm_d;
      end
      if (done) out_frame <= asm_d;
      out_valid <= done || (out_valid && !out_ready);
      if (out_valid && out_ready) frame_cnt <= frame_cnt + 8'd1;
      if (acc) {fld_hi, fld_gated, fld_lo} <= in_word;
    end
  end
`ifdef BUS_BREAKIN_PARITY_EN
  logic bad_w, bad_q;
  assign bad_w = ^{in_word, in_par};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
      par_err <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      if (flush) bad_q <= 1'b0;
      else if (acc) bad_q <= last ? 1'b0 : bad_q || bad_w;
      if (done) frame_bad <= bad_q || bad_w;
      if (acc && bad_w) par_err <= 1'b1;
    end
  end
`endif
endmodule
